// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: EX-stage multi-cycle multiply/divide unit that owns HI/LO and drives the HI/LO bypass.
module hilo_muldiv_unit #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        valid_ex,
  input  logic [2:0]  op_ex,
  input  logic [31:0] a_ex,
  input  logic [31:0] b_ex,
  output logic [63:0] hilo_ex,
  output logic [63:0] hilo_reg,
  output logic        stall_req,
  output logic        busy
);
  localparam logic [1:0] S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3;
  localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3, OP_DIVU = 3'd4;
  localparam logic [2:0] OP_MTHI = 3'd5, OP_MTLO = 3'd6;
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, a_q, a_d, b_q, b_d, rem_q, rem_d;
  logic [63:0] res_q, res_d;
  logic        sgn_q, sgn_d, mul_q, mul_d, qs_q, qs_d, rs_q, rs_d;
  logic [63:0] pipe_q [MUL_LATENCY];
  logic [63:0] prod, result;
  logic [32:0] shl;
  logic [31:0] diff, rem_n, quot_n, abs_a, abs_b;
  logic        ge, is_mul, is_div, sdiv;
  assign is_mul = (op_ex == OP_MULT) || (op_ex == OP_MULTU);
  assign is_div = (op_ex == OP_DIV) || (op_ex == OP_DIVU);
  assign sdiv   = op_ex == OP_DIV;
  assign abs_a  = (sdiv && a_ex[31]) ? -a_ex : a_ex;
  assign abs_b  = (sdiv && b_ex[31]) ? -b_ex : b_ex;
  // Low 64 bits of a 64x64 product of sign/zero-extended operands is the exact 32x32 result.
  assign prod   = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};
  // a_q shifts the dividend out at the top while quotient bits enter at the bottom.
  assign shl    = {rem_q, a_q[31]};
  assign ge     = shl >= {1'b0, b_q};
  assign diff   = shl[31:0] - b_q;
  assign rem_n  = ge ? diff : shl[31:0];
  assign quot_n = {a_q[30:0], ge};
  assign result = mul_q ? pipe_q[MUL_LATENCY-1] : res_q;
  assign hilo_reg = {hi_q, lo_q};
  assign busy     = state_q != S_IDLE;
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    res_d     = res_q;
    sgn_d     = sgn_q;
    mul_d     = mul_q;
    qs_d      = qs_q;
    rs_d      = rs_q;
    stall_req = 1'b0;
    hilo_ex   = {hi_q, lo_q};
    case (state_q)
      S_IDLE: begin
        if (valid_ex && is_mul) begin
          stall_req = 1'b1;
          a_d       = a_ex;
          b_d       = b_ex;
          sgn_d     = op_ex == OP_MULT;
          mul_d     = 1'b1;
          cnt_d     = '0;
          state_d   = S_MUL;
        end else if (valid_ex && is_div && b_ex != '0) begin
          stall_req = 1'b1;
          a_d       = abs_a;
          b_d       = abs_b;
          rem_d     = '0;
          qs_d      = sdiv && (a_ex[31] ^ b_ex[31]);
          rs_d      = sdiv && a_ex[31];
          mul_d     = 1'b0;
          cnt_d     = '0;
          state_d   = S_DIV;
        end else if (valid_ex && is_div) begin
          stall_req = 1'b1;
          res_d     = {a_ex, 32'hFFFF_FFFF};
          mul_d     = 1'b0;
          state_d   = S_DONE;
        end else if (valid_ex && op_ex == OP_MTHI) begin
          hilo_ex = {a_ex, lo_q};
          hi_d    = a_ex;
        end else if (valid_ex && op_ex == OP_MTLO) begin
          hilo_ex = {hi_q, a_ex};
          lo_d    = a_ex;
        end
      end
      S_MUL: begin
        stall_req = 1'b1;
        cnt_d     = (cnt_q == 5'(MUL_LATENCY - 1)) ? '0 : cnt_q + 5'd1;
        state_d   = (cnt_q == 5'(MUL_LATENCY - 1)) ? S_DONE : S_MUL;
      end
      S_DIV: begin
        stall_req = 1'b1;
        a_d       = quot_n;
        rem_d     = rem_n;
        cnt_d     = cnt_q + 5'd1;
        res_d     = {rs_q ? -rem_n : rem_n, qs_q ? -quot_n : quot_n};
        state_d   = (cnt_q == 5'd31) ? S_DONE : S_DIV;
      end
      default: begin
        hilo_ex      = result;
        {hi_d, lo_d} = result;
        state_d      = S_IDLE;
      end
    endcase
    if (flush) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      stall_req = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      res_q   <= '0;
      sgn_q   <= 1'b0;
      mul_q   <= 1'b0;
      qs_q    <= 1'b0;
      rs_q    <= 1'b0;
      for (int i = 0; i < MUL_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      res_q   <= res_d;
      sgn_q   <= sgn_d;
      mul_q   <= mul_d;
      qs_q    <= qs_d;
      rs_q    <= rs_d;
      pipe_q[0] <= prod;
      for (int i = 1; i < MUL_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
endmodule
